// File: rtl/counter16_sequencer_if.sv
// Command / counter-control bundle for counter16_sequencer.
// The master side is the requester plus the counter datapath (it supplies
// cnt_q); the slave side is the sequencer itself.
interface counter16_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_dir;
  logic             busy;
  logic             done;
  logic             wrapped;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, abort, cnt_q,
    input  cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir,
           busy, done, wrapped, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, abort, cnt_q,
    output cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir,
           busy, done, wrapped, aborted
  );
endinterface

// File: rtl/counter16_sequencer.sv
// Command-driven sequencer for the 16-bit counter datapath.
// Accepts LOAD / UP / DOWN commands in IDLE, then drives the counter's load
// strobe or enable for an exact number of cycles, finishing with a one-cycle
// done pulse. Sticky wrapped/aborted status holds until the next accept.
module counter16_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  counter16_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wrapped_q, wrapped_d;
  logic             aborted_q, aborted_d;

  // Counter is about to cross its boundary in the current direction.
  function automatic logic wrap_hit(input logic up, input logic [WIDTH-1:0] q);
    if (up) return (q == {WIDTH{1'b1}});
    else    return (q == {WIDTH{1'b0}});
  endfunction

  // State and command registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      data_q      <= '0;
      wrapped_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      wrapped_q   <= wrapped_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic: command accept, run countdown, wrap and abort tracking.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    data_d      = data_q;
    wrapped_d   = wrapped_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            OP_LOAD: begin
              data_d    = bus.cmd_data;
              wrapped_d = 1'b0;
              aborted_d = 1'b0;
              state_d   = S_LOAD;
            end
            OP_UP, OP_DOWN: begin
              dir_d     = (bus.cmd_op == OP_UP);
              wrapped_d = 1'b0;
              aborted_d = 1'b0;
              if (bus.cmd_len != '0) begin
                remaining_d = bus.cmd_len;
                state_d     = S_RUN;
              end else begin
                // Zero-length run completes without ever enabling the counter.
                state_d = S_DONE;
              end
            end
            default: begin
              // NOP is consumed with no visible effect.
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_LOAD: begin
        state_d = S_DONE;
      end

      S_RUN: begin
        if (wrap_hit(dir_q, bus.cnt_q)) wrapped_d = 1'b1;
        if (remaining_q == LEN_W'(1)) begin
          // Last enable cycle; an abort here is just a normal finish.
          remaining_d = '0;
          state_d     = S_DONE;
        end else if (bus.abort) begin
          remaining_d = '0;
          aborted_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          remaining_d = remaining_q - LEN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.cmd_ready    = (state_q == S_IDLE);
    bus.busy         = (state_q != S_IDLE);
    bus.cnt_load     = (state_q == S_LOAD);
    bus.cnt_en       = (state_q == S_RUN);
    bus.cnt_dir      = (state_q == S_RUN) && dir_q;
    bus.done         = (state_q == S_DONE);
    bus.cnt_load_val = data_q;
    bus.wrapped      = wrapped_q;
    bus.aborted      = aborted_q;
  end

endmodule

// File: tb/tb_counter16_sequencer.sv
// Bench for counter16_sequencer: directed vector table, hand-written corner
// sequences and randomized commands, all checked every cycle against a
// transaction-level model (a queue of expected per-cycle actions).
module tb_counter16_sequencer;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter16_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  counter16_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Simple counter datapath driven by the sequencer's controls.
  logic [15:0] cnt = 16'h0000;
  assign bus.cnt_q = cnt;
  always @(posedge clk) begin
    if (bus.cnt_load)    cnt <= bus.cnt_load_val;
    else if (bus.cnt_en) cnt <= bus.cnt_dir ? cnt + 16'd1 : cnt - 16'd1;
  end

  int checks = 0;
  int errors = 0;
  int en_seen = 0;

  // Reference model: each accepted command expands into the list of cycles it
  // will occupy; the head of the list is what the outputs must show now.
  typedef struct packed {
    logic load;
    logic en;
    logic dir;
    logic done;
  } step_t;

  step_t       sq[$];
  logic        m_wrapped = 1'b0;
  logic        m_aborted = 1'b0;
  logic [15:0] m_data    = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    m_wrapped = 1'b0;
    m_aborted = 1'b0;
    m_data    = 16'h0000;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [15:0] d,
                            input logic [7:0] len, input logic ab, input logic [15:0] q);
    step_t h;
    step_t s;
    int    n_en;
    if (sq.size() != 0) begin
      h = sq[0];
      if (h.en) begin
        if (h.dir ? (q == 16'hFFFF) : (q == 16'h0000)) m_wrapped = 1'b1;
        n_en = 0;
        foreach (sq[i]) if (sq[i].en) n_en++;
        if (ab && n_en > 1) begin
          sq.delete();
          sq.push_back(h);
          s = '0; s.done = 1'b1;
          sq.push_back(s);
          m_aborted = 1'b1;
        end
      end
      void'(sq.pop_front());
    end else if (v) begin
      if (op == 2'b01) begin
        m_data = d; m_wrapped = 1'b0; m_aborted = 1'b0;
        s = '0; s.load = 1'b1; sq.push_back(s);
        s = '0; s.done = 1'b1; sq.push_back(s);
      end else if (op[1]) begin
        m_wrapped = 1'b0; m_aborted = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
          s = '0; s.en = 1'b1; s.dir = (op == 2'b10); sq.push_back(s);
        end
        s = '0; s.done = 1'b1; sq.push_back(s);
      end
    end
  endtask

  task automatic check_model();
    step_t h;
    h = (sq.size() != 0) ? sq[0] : '0;
    chk("cmd_ready",    32'(bus.cmd_ready),    32'(sq.size() == 0));
    chk("busy",         32'(bus.busy),         32'(sq.size() != 0));
    chk("cnt_load",     32'(bus.cnt_load),     32'(h.load));
    chk("cnt_en",       32'(bus.cnt_en),       32'(h.en));
    chk("cnt_dir",      32'(bus.cnt_dir),      32'(h.en & h.dir));
    chk("done",         32'(bus.done),         32'(h.done));
    chk("wrapped",      32'(bus.wrapped),      32'(m_wrapped));
    chk("aborted",      32'(bus.aborted),      32'(m_aborted));
    chk("cnt_load_val", 32'(bus.cnt_load_val), 32'(m_data));
  endtask

  // One clock: capture inputs, step the model for the edge, compare outputs.
  task automatic cycle();
    logic        v, ab;
    logic [1:0]  op;
    logic [15:0] d, q;
    logic [7:0]  len;
    v = bus.cmd_valid; ab = bus.abort; op = bus.cmd_op;
    d = bus.cmd_data; len = bus.cmd_len; q = cnt;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_edge(v, op, d, len, ab, q);
    if (bus.cnt_en) en_seen++;
    check_model();
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [7:0] len);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d; bus.cmd_len = len;
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (!bus.cmd_ready && k < budget) begin cycle(); k++; end
    if (!bus.cmd_ready) chk("idle_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin cycle(); k++; end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [15:0] d;
    logic [7:0]  len;
    logic [7:0]  exp; // {ready, load, en, dir, busy, done, wrapped, aborted}
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          k;
    logic [7:0]  act;
    int unsigned r;

    tbl[0] = '{1'b1, 2'b01, 16'hBEEF, 8'd0, 8'b0100_1000};
    tbl[1] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0000_1100};
    tbl[2] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b1000_0000};
    tbl[3] = '{1'b1, 2'b10, 16'h0000, 8'd5, 8'b0011_1000};
    tbl[4] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0011_1000};
    tbl[5] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0011_1000};
    tbl[6] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0011_1000};
    tbl[7] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0011_1000};
    tbl[8] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b0000_1100};
    tbl[9] = '{1'b0, 2'b00, 16'h0000, 8'd0, 8'b1000_0000};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 16'h0000;
    bus.cmd_len = 8'd0; bus.abort = 1'b0;
    cycle();
    cycle();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    reset = 1'b0;

    // Directed table: LOAD BEEF, then UP for 5 cycles.
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = tbl[i].v; bus.cmd_op = tbl[i].op;
      bus.cmd_data = tbl[i].d;  bus.cmd_len = tbl[i].len;
      cycle();
      act = {bus.cmd_ready, bus.cnt_load, bus.cnt_en, bus.cnt_dir,
             bus.busy, bus.done, bus.wrapped, bus.aborted};
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
      if (i == 0) chk("vec_load_val", 32'(bus.cnt_load_val), 32'h0000BEEF);
    end
    bus.cmd_valid = 1'b0;

    // Wrap on the way up, cleared by the next accept.
    send(2'b01, 16'hFFFE, 8'd0);
    run_until_idle(8);
    send(2'b10, 16'h0000, 8'd4);
    wait_done(10);
    chk("wrap_up_set", 32'(bus.wrapped), 32'd1);
    chk("cnt_after_wrap", 32'(cnt), 32'h00000002);
    cycle();
    send(2'b01, 16'h0005, 8'd0);
    chk("wrap_clr_accept", 32'(bus.wrapped), 32'd0);
    run_until_idle(8);
    send(2'b11, 16'h0000, 8'd2);
    wait_done(10);
    chk("wrap_down_none", 32'(bus.wrapped), 32'd0);
    cycle();

    // Abort in the third RUN cycle of a 10-cycle DOWN run.
    send(2'b01, 16'd100, 8'd0);
    run_until_idle(8);
    en_seen = 0;
    send(2'b11, 16'h0000, 8'd10);
    cycle();
    cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk("abort_done",    32'(bus.done),    32'd1);
    chk("abort_flag",    32'(bus.aborted), 32'd1);
    chk("abort_en_cnt",  32'(en_seen),     32'd3);
    cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk("abort_idle_busy",  32'(bus.busy),      32'd0);
    chk("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);

    // Zero-length run, NOP, and a command held during a run.
    en_seen = 0;
    send(2'b10, 16'h0000, 8'd0);
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_no_en", 32'(en_seen), 32'd0);
    cycle();
    send(2'b00, 16'h1111, 8'd7);
    chk("nop_busy", 32'(bus.busy), 32'd0);
    chk("nop_done", 32'(bus.done), 32'd0);
    send(2'b10, 16'h0000, 8'd3);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 16'h1234;
    k = 0;
    while (!bus.cnt_load && k < 10) begin cycle(); k++; end
    bus.cmd_valid = 1'b0;
    chk("held_accept_delay", 32'(k), 32'd5);
    run_until_idle(8);

    // Reset in the middle of a long run.
    send(2'b10, 16'h0000, 8'd200);
    repeat (10) cycle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_en",    32'(bus.cnt_en), 32'd0);
    chk("rst_mid_busy",  32'(bus.busy),   32'd0);
    chk("rst_mid_done",  32'(bus.done),   32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_rel_ready", 32'(bus.cmd_ready), 32'd1);
    send(2'b01, 16'hA5A5, 8'd0);
    chk("rst_rel_load", 32'(bus.cnt_load), 32'd1);
    run_until_idle(8);

    // Randomized commands against the model.
    repeat (1500) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7);
      if (r == 0)      bus.cmd_len = 8'd0;
      else if (r == 1) bus.cmd_len = 8'($urandom_range(20, 60));
      else             bus.cmd_len = 8'($urandom_range(1, 6));
      r = $urandom_range(0, 3);
      if (r == 0)      bus.cmd_data = 16'hFFFE;
      else if (r == 1) bus.cmd_data = 16'h0001;
      else             bus.cmd_data = 16'($urandom);
      bus.abort = ($urandom_range(0, 7) == 0);
      cycle();
    end
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    run_until_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
